// File: rtl/mux8way_arbiter_if.sv
// Handshake bundle between the eight producer lanes, the merger and the
// single downstream consumer. "slave" is the merger's view, "master" is the
// view of whatever drives the lanes and consumes the merged stream.
interface mux8way_arbiter_if #(
    parameter int WIDTH = 16
);
    logic [7:0]         in_valid;
    logic [8*WIDTH-1:0] in_data;
    logic [7:0]         in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [2:0]         out_sel;
    logic               out_ready;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/mux8way_arbiter.sv
// Eight-lane round-robin merger. One output register holds the granted word
// and its source lane; the pointer names the lane with highest priority and
// moves to just past the last winner, so every lane is served within 8 grants.
module mux8way_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    mux8way_arbiter_if.slave     bus
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [2:0]       out_sel_q,   out_sel_d;
    logic [2:0]       ptr_q,       ptr_d;

    logic             load;
    logic             found;
    logic [2:0]       g;
    logic [2:0]       idx;
    logic [WIDTH-1:0] lane_data;

    // The register may take a new word when it is empty or being consumed.
    assign load = !out_valid_q || bus.out_ready;

    // Scan lanes starting at the pointer; first valid lane wins.
    always_comb begin
        found = 1'b0;
        g     = 3'd0;
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr_q + 3'(i);
            if (!found && bus.in_valid[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
    end

    // Pick the winning lane's word; only feeds the register, never an output.
    always_comb begin
        lane_data = '0;
        for (int k = 0; k < 8; k++) begin
            if (g == 3'(k)) begin
                lane_data = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Accept at most one lane; nothing is accepted while reset is held.
    assign bus.in_ready = (load && found && !reset) ? (8'd1 << g) : 8'd0;

    // Next-state: load on grant, empty on idle load, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load) begin
            if (found) begin
                out_valid_d = 1'b1;
                out_data_d  = lane_data;
                out_sel_d   = g;
                ptr_d       = g + 3'd1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers; reset discards any held word immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 3'd0;
            ptr_q       <= 3'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux8way_arbiter.sv
// Self-checking bench for mux8way_arbiter: directed scenarios followed by
// randomized producer/consumer traffic, all compared against a behavioural
// model of the merger kept here.
module tb_mux8way_arbiter;

    localparam int WIDTH = 16;

    logic clk;
    logic reset;

    mux8way_arbiter_if #(.WIDTH(WIDTH)) ifc ();

    mux8way_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // Behavioural model of the output register and priority pointer.
    int               m_ptr;
    bit               m_vld;
    logic [WIDTH-1:0] m_data;
    int               m_sel;

    // Producer side view.
    logic [WIDTH-1:0] lane_d [8];
    logic [7:0]       lane_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive();
        ifc.in_valid = lane_v;
        for (int k = 0; k < 8; k++) ifc.in_data[k*WIDTH +: WIDTH] = lane_d[k];
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_vld  = 1'b0;
        m_data = '0;
        m_sel  = 0;
    endtask

    // One clock cycle: check combinational ready and held outputs against
    // the model, take the edge, advance the model. Returns granted lane or -1.
    task automatic cycle(output int acc);
        bit         load;
        bit         found;
        int         g;
        logic [7:0] exp_rdy;
        drive();
        #1;
        load  = !m_vld || ifc.out_ready;
        found = 1'b0;
        g     = -1;
        for (int i = 0; i < 8; i++) begin
            if (!found && lane_v[(m_ptr + i) % 8]) begin
                found = 1'b1;
                g     = (m_ptr + i) % 8;
            end
        end
        exp_rdy = (load && found) ? 8'(1 << g) : 8'h00;
        chk("in_ready",  32'(ifc.in_ready),  32'(exp_rdy));
        chk("out_valid", 32'(ifc.out_valid), 32'(m_vld));
        chk("out_data",  32'(ifc.out_data),  32'(m_data));
        chk("out_sel",   32'(ifc.out_sel),   32'(m_sel));
        @(posedge clk);
        acc = -1;
        if (load) begin
            if (found) begin
                m_vld  = 1'b1;
                m_data = lane_d[g];
                m_sel  = g;
                m_ptr  = (g + 1) % 8;
                acc    = g;
            end else begin
                m_vld = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int acc;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        lane_v = 8'h00;
        for (int k = 0; k < 8; k++) lane_d[k] = '0;
        ifc.out_ready = 1'b0;
        model_reset();
        drive();

        // Reset state, with a lane valid to show ready is suppressed.
        @(negedge clk);
        lane_v = 8'h20;
        lane_d[5] = 16'h1234;
        ifc.out_ready = 1'b1;
        drive();
        #1;
        chk("rst_in_ready",  32'(ifc.in_ready), 32'h0);
        chk("rst_out_valid", 32'(ifc.out_valid), 32'h0);
        chk("rst_out_data",  32'(ifc.out_data), 32'h0);
        chk("rst_out_sel",   32'(ifc.out_sel), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Single lane after reset.
        cycle(acc);
        chk("t1_grant", 32'(acc), 32'd5);
        lane_v = 8'h00;
        drive();
        #1;
        chk("t1_out_valid", 32'(ifc.out_valid), 32'h1);
        chk("t1_out_data",  32'(ifc.out_data), 32'h1234);
        chk("t1_out_sel",   32'(ifc.out_sel), 32'd5);
        chk("t1_ptr",       32'(dut.ptr_q), 32'd6);
        cycle(acc);

        // Full contention from reset: lanes served 0..7,0,1.
        do_reset();
        for (int k = 0; k < 8; k++) lane_d[k] = 16'(k << 4);
        lane_v = 8'hFF;
        for (int n = 0; n < 10; n++) begin
            cycle(acc);
            chk("t2_order", 32'(acc), 32'(n % 8));
        end
        lane_v = 8'h00;
        cycle(acc);

        // Wrap priority: pointer at 6, lanes 1 and 7 compete.
        do_reset();
        lane_v = 8'h20;
        lane_d[5] = 16'h5555;
        cycle(acc);
        chk("t3_first", 32'(acc), 32'd5);
        lane_v = 8'h82;
        lane_d[1] = 16'h1111;
        lane_d[7] = 16'h7777;
        cycle(acc);
        chk("t3_wrap_a", 32'(acc), 32'd7);
        lane_v = 8'h02;
        cycle(acc);
        chk("t3_wrap_b", 32'(acc), 32'd1);
        lane_v = 8'h00;
        cycle(acc);

        // Backpressure: hold 0xBEEF from lane 2 while lane 3 waits.
        lane_v = 8'h04;
        lane_d[2] = 16'hBEEF;
        cycle(acc);
        chk("t4_load", 32'(acc), 32'd2);
        lane_v = 8'h08;
        lane_d[3] = 16'h3333;
        ifc.out_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            cycle(acc);
            chk("t4_stall_grant", 32'(acc), 32'hFFFF_FFFF);
            chk("t4_hold_data", 32'(ifc.out_data), 32'hBEEF);
            chk("t4_hold_sel",  32'(ifc.out_sel), 32'd2);
        end
        ifc.out_ready = 1'b1;
        cycle(acc);
        chk("t4_resume", 32'(acc), 32'd3);
        lane_v = 8'h00;
        drive();
        #1;
        chk("t4_no_bubble_v", 32'(ifc.out_valid), 32'h1);
        chk("t4_no_bubble_s", 32'(ifc.out_sel), 32'd3);

        // Drain: idle lanes empty the register but keep data/sel.
        cycle(acc);
        #1;
        chk("t5_drain_v", 32'(ifc.out_valid), 32'h0);
        chk("t5_drain_d", 32'(ifc.out_data), 32'h3333);
        chk("t5_drain_s", 32'(ifc.out_sel), 32'd3);
        @(negedge clk);

        // Asynchronous reset between edges while FULL.
        lane_v = 8'h10;
        lane_d[4] = 16'hA5A5;
        cycle(acc);
        lane_v = 8'h00;
        ifc.out_ready = 1'b0;
        drive();
        #3;
        reset = 1'b1;
        #1;
        chk("t6_async_v", 32'(ifc.out_valid), 32'h0);
        chk("t6_async_d", 32'(ifc.out_data), 32'h0);
        chk("t6_async_s", 32'(ifc.out_sel), 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        lane_v = 8'hFF;
        ifc.out_ready = 1'b1;
        cycle(acc);
        chk("t6_first_after", 32'(acc), 32'd0);
        lane_v = 8'h00;
        cycle(acc);

        // Randomized traffic: producers hold words until accepted.
        for (int n = 0; n < 400; n++) begin
            ifc.out_ready = ($urandom_range(0, 3) != 0);
            cycle(acc);
            if (acc >= 0) lane_v[acc] = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (!lane_v[k] && $urandom_range(0, 2) == 0) begin
                    lane_v[k] = 1'b1;
                    lane_d[k] = 16'($urandom);
                end
            end
        end
        ifc.out_ready = 1'b1;
        lane_v = 8'h00;
        cycle(acc);
        cycle(acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
